mem_responder: RTL

//   Memory-side responder for the control FSM's memory interface (ram_addr/ram_data/sram_we_n -> ram_q).

---
 rtl/mem_responder_if.sv | 41 ++++
 rtl/mem_responder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - core memory port and host load port bundle for mem_responder
// Purpose: groups the core read/write port and the host load port of the memory responder.
// Signals:
//   ram_addr  16    core word address (upper bits beyond AW are aliased away)
//   ram_data  DW    core write data
//   sram_we_n 1     core write enable, active-low
//   ram_q     DW    registered core read data
//   core_hold 1     core must stay stalled while the RAM is being loaded
//   ld_start  1     request to re-enter load mode from run mode
//   ld_valid  1     host load word valid
//   ld_data   DW    host load word
//   ld_last   1     marks the final load word
//   ld_ready  1     responder accepts a load word this cycle
//   ld_count  AW+1  words loaded since load mode was entered
// Modports: master = core/host side, slave = responder side.
interface mem_responder_if #(
   parameter int DW = 16,
   parameter int AW = 8
);
   logic [15:0]   ram_addr;
   logic [DW-1:0] ram_data;
   logic          sram_we_n;
   logic [DW-1:0] ram_q;
   logic          core_hold;
   logic          ld_start;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_last;
   logic          ld_ready;
   logic [AW:0]   ld_count;

   modport master (
      output ram_addr, ram_data, sram_we_n, ld_start, ld_valid, ld_data, ld_last,
      input  ram_q, core_hold, ld_ready, ld_count
   );

   modport slave (
      input  ram_addr, ram_data, sram_we_n, ld_start, ld_valid, ld_data, ld_last,
      output ram_q, core_hold, ld_ready, ld_count
   );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - DEPTH x DW synchronous RAM serving core reads/writes with a host load mode
// Purpose: stands in for main memory behind the control FSM. After reset the block is in LOAD,
//   where the host streams words into the RAM from address 0 while the core is held. Once the
//   last word (ld_last or the top address) is accepted it switches to RUN and serves core
//   accesses with a fixed one-cycle registered read latency. ld_start returns it to LOAD.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-low reset (RAM contents are not cleared)
//   bus  slave modport of mem_responder_if (core port + host load port)
module mem_responder #(
   parameter int DW = 16,
   parameter int AW = 8
) (
   input  logic           clk,
   input  logic           rst,
   mem_responder_if.slave bus
);

   localparam int          DEPTH      = 1 << AW;
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t        state_q;
   state_t        state_d;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] ptr_q;
   logic [AW:0]   count_q;
   logic [DW-1:0] q_q;

   logic          core_hold_o;
   logic          ld_ready_o;
   logic          ld_accept;
   logic          load_exit;
   logic          run_write;
   logic          run_restart;
   logic [AW-1:0] core_addr;

   // Address bits above AW only alias; fold them into an intentionally unused net.
   generate
      if (AW < 16) begin : g_addr_alias
         logic unused_addr_bits;
         assign unused_addr_bits = ^bus.ram_addr[15:AW];
      end
   endgenerate

   assign core_addr   = bus.ram_addr[AW-1:0];
   // ld_ready is 1 for the whole of LOAD, so acceptance only needs ld_valid.
   assign ld_accept   = (state_q == ST_LOAD) && bus.ld_valid;
   assign load_exit   = ld_accept && (bus.ld_last || (ptr_q == {AW{1'b1}}));
   assign run_write   = (state_q == ST_RUN) && !bus.sram_we_n;
   assign run_restart = (state_q == ST_RUN) && bus.ld_start;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: if (load_exit)   state_d = ST_RUN;
         ST_RUN:  if (bus.ld_start) state_d = ST_LOAD;
         default: state_d = ST_LOAD;
      endcase
   end

   // Outputs decoded from the registered state only, so no input reaches them combinationally.
   always_comb begin
      core_hold_o = 1'b1;
      ld_ready_o  = 1'b1;
      case (state_q)
         ST_LOAD: begin
            core_hold_o = 1'b1;
            ld_ready_o  = 1'b1;
         end
         ST_RUN: begin
            core_hold_o = 1'b0;
            ld_ready_o  = 1'b0;
         end
         default: begin
            core_hold_o = 1'b1;
            ld_ready_o  = 1'b1;
         end
      endcase
   end

   // Load pointer, load counter and read data register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q   <= '0;
         count_q <= '0;
         q_q     <= '0;
      end else begin
         if (ld_accept) begin
            // Pointer wraps to 0 on the top word, which is also the exit word.
            ptr_q <= ptr_q + 1'b1;
            if (count_q != FULL_COUNT) begin
               count_q <= count_q + 1'b1;
            end
         end else if (run_restart) begin
            ptr_q   <= '0;
            count_q <= '0;
         end
         // Read before write: a same-address write this edge is seen on the next read.
         if (state_q == ST_RUN) begin
            q_q <= mem[core_addr];
         end
      end
   end

   // RAM array has no reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (ld_accept) begin
         mem[ptr_q] <= bus.ld_data;
      end else if (run_write) begin
         mem[core_addr] <= bus.ram_data;
      end
   end

   assign bus.ram_q     = q_q;
   assign bus.core_hold = core_hold_o;
   assign bus.ld_ready  = ld_ready_o;
   assign bus.ld_count  = count_q;

endmodule
